// File: rtl/adex_param_pkg.sv
// Constants shared by the AdEx parameter streamer and the neuron's nibble-serial loader.
// Also holds the streamer state encoding and the strobe-to-nibble mapping.
package adex_param_pkg;

  localparam int NUM_PARAMS  = 8;
  localparam int NUM_STROBES = 18;

  localparam logic [3:0] FOOTER_NIB  = 4'hF;
  localparam logic [4:0] LAST_STROBE = 5'(NUM_STROBES - 1);

  // Byte k lives at [8k+7:8k]: DeltaT, TauW, a, b, Vreset, VT, Ibias, C
  localparam logic [8*NUM_PARAMS-1:0] DEFAULT_PARAMS =
    {8'd200, 8'd143, 8'd78, 8'd63, 8'd168, 8'd130, 8'd228, 8'd130};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STR_HI,
    ST_STR_LO,
    ST_HOLD
  } streamer_state_e;

  // Strobe 0 arms the loader, 1..16 carry bytes high nibble first, 17 is the footer
  function automatic logic [3:0] strobe_nibble(input logic [8*NUM_PARAMS-1:0] bytes,
                                               input logic [4:0] s);
    logic [7:0] b;
    b = 8'h00;
    strobe_nibble = 4'h0;
    if (s == LAST_STROBE) begin
      strobe_nibble = FOOTER_NIB;
    end else if (s != 5'd0) begin
      b = bytes[8*((int'(s) - 1) / 2) +: 8];
      strobe_nibble = s[0] ? b[7:4] : b[3:0];
    end
  endfunction

endpackage

// File: rtl/adex_param_streamer.sv
// Transmit side of the neuron's nibble-serial parameter-load protocol: snapshots eight bytes
// on start and strobes them out as arm, 16 data nibbles and a footer, then holds load_mode.
module adex_param_streamer
  import adex_param_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int HI_CYCLES    = 2,
  parameter int LO_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] params_in,
  output logic        load_mode,
  output logic        load_enable,
  output logic [3:0]  nibble,
  output logic        busy,
  output logic        done
);

  localparam int MAX_SH    = (SETUP_CYCLES > HI_CYCLES) ? SETUP_CYCLES : HI_CYCLES;
  localparam int MAX_LH    = (LO_CYCLES > HOLD_CYCLES) ? LO_CYCLES : HOLD_CYCLES;
  localparam int MAX_PHASE = (MAX_SH > MAX_LH) ? MAX_SH : MAX_LH;
  localparam int PHASE_W   = $clog2(MAX_PHASE) + 1;

  localparam logic [PHASE_W-1:0] SETUP_LAST = PHASE_W'(SETUP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HI_LAST    = PHASE_W'(HI_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LO_LAST    = PHASE_W'(LO_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(HOLD_CYCLES - 1);

  streamer_state_e    state, state_d;
  logic [PHASE_W-1:0] phase_cnt, phase_d;
  logic [4:0]         strobe_cnt, strobe_d;
  logic [63:0]        snapshot;
  logic               load_mode_d, load_enable_d, busy_d, done_d;
  logic [3:0]         nibble_d;
  logic               accept;

  assign accept = (state == ST_IDLE) && start && !abort;

  // Every output is registered from its next-cycle value so the neuron sees glitch-free lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      phase_cnt   <= '0;
      strobe_cnt  <= '0;
      snapshot    <= '0;
      load_mode   <= 1'b0;
      load_enable <= 1'b0;
      nibble      <= 4'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      phase_cnt   <= phase_d;
      strobe_cnt  <= strobe_d;
      if (accept) snapshot <= params_in;
      load_mode   <= load_mode_d;
      load_enable <= load_enable_d;
      nibble      <= nibble_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    phase_d  = phase_cnt;
    strobe_d = strobe_cnt;
    if (abort) begin
      state_d  = ST_IDLE;
      phase_d  = '0;
      strobe_d = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_SETUP;
            phase_d  = '0;
            strobe_d = '0;
          end
        end
        ST_SETUP: begin
          if (phase_cnt == SETUP_LAST) begin
            state_d = ST_STR_HI;
            phase_d = '0;
          end else begin
            phase_d = phase_cnt + PHASE_W'(1);
          end
        end
        ST_STR_HI: begin
          if (phase_cnt == HI_LAST) begin
            state_d = ST_STR_LO;
            phase_d = '0;
          end else begin
            phase_d = phase_cnt + PHASE_W'(1);
          end
        end
        // The footer's low phase is the last strobe cycle; the counter stops at 17
        ST_STR_LO: begin
          if (phase_cnt == LO_LAST) begin
            phase_d = '0;
            if (strobe_cnt == LAST_STROBE) begin
              state_d = ST_HOLD;
            end else begin
              state_d  = ST_STR_HI;
              strobe_d = strobe_cnt + 5'd1;
            end
          end else begin
            phase_d = phase_cnt + PHASE_W'(1);
          end
        end
        ST_HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            state_d = ST_IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_cnt + PHASE_W'(1);
          end
        end
        default: begin
          state_d  = ST_IDLE;
          phase_d  = '0;
          strobe_d = '0;
        end
      endcase
    end
  end

  // The nibble is loaded only as load_enable rises, so it is stable for the whole strobe
  always_comb begin
    load_mode_d   = (state_d != ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    load_enable_d = (state_d == ST_STR_HI);
    done_d        = (state == ST_HOLD) && (state_d == ST_IDLE) && !abort;
    nibble_d      = nibble;
    if (abort && (state != ST_IDLE)) begin
      nibble_d = 4'h0;
    end else if ((state_d == ST_STR_HI) && (state != ST_STR_HI)) begin
      nibble_d = strobe_nibble(snapshot, strobe_d);
    end
  end

endmodule
